// File: rtl/note_judge_if.sv
// note_judge_if -- bundles the judge's song-side inputs and scoring outputs.
//   frame_clk   : note-shift clock, sampled as data inside the judge
//   n_reg       : falling-note register, [lane][row], row grows downward
//   buttons     : fret buttons, active-high, synchronous to the system clock
//   active      : judging enable
//   score       : accumulated points
//   streak      : consecutive-hit count
//   multiplier  : current score multiplier, 1..4
//   hit_pulse   : per-lane one-cycle hit strobe
//   miss_pulse  : per-lane one-cycle miss strobe
//   ghost_pulse : one-cycle strobe for a press with nothing to hit
// master drives the inputs (game logic / bench), slave is the judge.
interface note_judge_if;
  logic              frame_clk;
  logic [3:0][359:0] n_reg;
  logic [3:0]        buttons;
  logic              active;
  logic [15:0]       score;
  logic [9:0]        streak;
  logic [2:0]        multiplier;
  logic [3:0]        hit_pulse;
  logic [3:0]        miss_pulse;
  logic              ghost_pulse;

  modport master (
    output frame_clk, n_reg, buttons, active,
    input  score, streak, multiplier, hit_pulse, miss_pulse, ghost_pulse
  );

  modport slave (
    input  frame_clk, n_reg, buttons, active,
    output score, streak, multiplier, hit_pulse, miss_pulse, ghost_pulse
  );
endinterface

// File: rtl/note_judge.sv
// note_judge -- judges fret presses against falling notes inside a hit window
// and keeps score, streak and multiplier.
//   Clk   : system clock, the only clock
//   Reset : asynchronous active-high reset
//   bus   : note_judge_if.slave (song inputs in, scoring outputs out)
// Each lane keeps a "consumed" mask over the window rows so one note can be
// hit only once; the mask scrolls with the notes on every frame tick.
module note_judge #(
  parameter int HIT_LO = 330,
  parameter int HIT_HI = 349,
  parameter int PTS    = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  note_judge_if.slave bus
);
  localparam int W = HIT_HI - HIT_LO + 1;

  function automatic logic [15:0] sat_score(input logic [31:0] v);
    return (v > 32'd65535) ? 16'hFFFF : v[15:0];
  endfunction

  function automatic logic [9:0] sat_streak(input logic [10:0] v);
    return (v > 11'd999) ? 10'd999 : v[9:0];
  endfunction

  function automatic logic [2:0] mult_of(input logic [9:0] s);
    if (s >= 10'd30)      return 3'd4;
    else if (s >= 10'd20) return 3'd3;
    else if (s >= 10'd10) return 3'd2;
    else                  return 3'd1;
  endfunction

  logic                fsync1_q, fsync1_d;
  logic                fsync2_q, fsync2_d;
  logic                fprev_q, fprev_d;
  logic [3:0]          buttons_q, buttons_d;
  logic [3:0][W-1:0]   consumed_q, consumed_d;
  logic [15:0]         score_q, score_d;
  logic [9:0]          streak_q, streak_d;
  logic [2:0]          multiplier_q, multiplier_d;
  logic [3:0]          hit_pulse_q, hit_pulse_d;
  logic [3:0]          miss_pulse_q, miss_pulse_d;
  logic                ghost_pulse_q, ghost_pulse_d;

  logic                tick;
  logic [3:0]          press;
  logic [3:0][W-1:0]   win;
  logic [3:0][W-1:0]   avail;
  logic [3:0][W-1:0]   pick;
  logic [2:0]          hit_cnt;
  logic [31:0]         gain;

  always_comb begin
    fsync1_d  = bus.frame_clk;
    fsync2_d  = fsync1_q;
    fprev_d   = fsync2_q;
    buttons_d = bus.buttons;

    tick  = fsync2_q & ~fprev_q;
    press = bus.buttons & ~buttons_q;

    consumed_d    = consumed_q;
    hit_pulse_d   = '0;
    miss_pulse_d  = '0;
    ghost_pulse_d = 1'b0;
    win           = '0;
    avail         = '0;
    pick          = '0;

    for (int l = 0; l < 4; l++) begin
      win[l]   = bus.n_reg[l][HIT_HI:HIT_LO];
      avail[l] = win[l] & ~consumed_q[l];
      // Highest set bit wins: the note closest to the bottom of the window.
      for (int k = 0; k < W; k++) begin
        if (avail[l][k]) begin
          pick[l]    = '0;
          pick[l][k] = 1'b1;
        end
      end
      if (press[l]) begin
        if (|avail[l]) begin
          hit_pulse_d[l] = 1'b1;
          consumed_d[l]  = consumed_q[l] | pick[l];
        end else begin
          ghost_pulse_d = 1'b1;
        end
      end
      // Miss is judged on the post-hit mask so a same-cycle hit cannot miss.
      if (tick) begin
        miss_pulse_d[l] = win[l][W-1] & ~consumed_d[l][W-1];
        consumed_d[l]   = consumed_d[l] << 1;
      end
    end

    hit_cnt = {2'b00, hit_pulse_d[0]} + {2'b00, hit_pulse_d[1]}
            + {2'b00, hit_pulse_d[2]} + {2'b00, hit_pulse_d[3]};
    gain    = 32'(PTS) * {29'd0, multiplier_q} * {29'd0, hit_cnt};
    score_d = sat_score({16'd0, score_q} + gain);
    if ((|miss_pulse_d) || ghost_pulse_d) streak_d = '0;
    else streak_d = sat_streak({1'b0, streak_q} + {8'd0, hit_cnt});

    // Disabled: judging frozen, masks flushed, edge detectors still run.
    if (!bus.active) begin
      consumed_d    = '0;
      hit_pulse_d   = '0;
      miss_pulse_d  = '0;
      ghost_pulse_d = 1'b0;
      score_d       = score_q;
      streak_d      = streak_q;
    end

    multiplier_d = mult_of(streak_d);
  end

  // ---- register stage: all outputs and state ----
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fsync1_q      <= 1'b0;
      fsync2_q      <= 1'b0;
      fprev_q       <= 1'b0;
      buttons_q     <= '0;
      consumed_q    <= '0;
      score_q       <= '0;
      streak_q      <= '0;
      multiplier_q  <= 3'd1;
      hit_pulse_q   <= '0;
      miss_pulse_q  <= '0;
      ghost_pulse_q <= 1'b0;
    end else begin
      fsync1_q      <= fsync1_d;
      fsync2_q      <= fsync2_d;
      fprev_q       <= fprev_d;
      buttons_q     <= buttons_d;
      consumed_q    <= consumed_d;
      score_q       <= score_d;
      streak_q      <= streak_d;
      multiplier_q  <= multiplier_d;
      hit_pulse_q   <= hit_pulse_d;
      miss_pulse_q  <= miss_pulse_d;
      ghost_pulse_q <= ghost_pulse_d;
    end
  end

  assign bus.score       = score_q;
  assign bus.streak      = streak_q;
  assign bus.multiplier  = multiplier_q;
  assign bus.hit_pulse   = hit_pulse_q;
  assign bus.miss_pulse  = miss_pulse_q;
  assign bus.ghost_pulse = ghost_pulse_q;
endmodule

// File: tb/tb_note_judge.sv
// tb_note_judge -- self-checking bench for note_judge: reset state, a table of
// single-press vectors, hand-written multi-cycle scenarios, and a randomized
// run compared against a row-level reference model.
module tb_note_judge;
  localparam int HIT_LO = 330;
  localparam int HIT_HI = 349;
  localparam int PTS    = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  note_judge_if bus ();

  note_judge #(.HIT_LO(HIT_LO), .HIT_HI(HIT_HI), .PTS(PTS)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (row-based) ----------------
  int         m_score, m_streak;
  bit         m_cons[4][360];
  logic [3:0] m_hit, m_miss;
  logic       m_ghost;
  logic [3:0] m_btn_prev;
  logic       m_fc0, m_fc1, m_fc2;

  function automatic int ref_mult(input int s);
    int m;
    m = s / 10 + 1;
    return (m > 4) ? 4 : m;
  endfunction

  task automatic model_reset();
    m_score = 0; m_streak = 0;
    foreach (m_cons[l, r]) m_cons[l][r] = 1'b0;
    m_hit = '0; m_miss = '0; m_ghost = 1'b0;
    m_btn_prev = '0;
    m_fc0 = 1'b0; m_fc1 = 1'b0; m_fc2 = 1'b0;
  endtask

  task automatic model_step();
    logic       tk;
    logic [3:0] pr;
    int         h, m;
    bit         found;
    tk = m_fc1 & ~m_fc2;
    pr = bus.buttons & ~m_btn_prev;
    m_fc2 = m_fc1; m_fc1 = m_fc0; m_fc0 = bus.frame_clk;
    m_btn_prev = bus.buttons;
    m_hit = '0; m_miss = '0; m_ghost = 1'b0;
    if (!bus.active) begin
      foreach (m_cons[l, r]) m_cons[l][r] = 1'b0;
      return;
    end
    h = 0;
    for (int l = 0; l < 4; l++) begin
      if (pr[l]) begin
        found = 1'b0;
        for (int r = HIT_HI; r >= HIT_LO; r--) begin
          if (!found && bus.n_reg[l][r] && !m_cons[l][r]) begin
            m_cons[l][r] = 1'b1; found = 1'b1; m_hit[l] = 1'b1; h++;
          end
        end
        if (!found) m_ghost = 1'b1;
      end
    end
    if (tk) begin
      for (int l = 0; l < 4; l++) begin
        if (bus.n_reg[l][HIT_HI] && !m_cons[l][HIT_HI]) m_miss[l] = 1'b1;
        for (int r = HIT_HI; r > HIT_LO; r--) m_cons[l][r] = m_cons[l][r-1];
        m_cons[l][HIT_LO] = 1'b0;
      end
    end
    m = ref_mult(m_streak);
    m_score = m_score + PTS * m * h;
    if (m_score > 65535) m_score = 65535;
    if (m_miss != 0 || m_ghost) m_streak = 0;
    else m_streak = (m_streak + h > 999) ? 999 : m_streak + h;
  endtask

  // One clock: model consumes the inputs the DUT will sample at this edge.
  task automatic cyc();
    if (rst) model_reset();
    else model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.buttons = '0;
    bus.frame_clk = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic tap(input logic [3:0] b);
    bus.buttons = b;
    cyc();
    bus.buttons = '0;
    cyc();
  endtask

  typedef struct {
    string      name;
    logic [3:0] lanes;
    int         row;
    logic [3:0] btn;
    logic [3:0] exp_hit;
    logic       exp_ghost;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   g, used, guard;
    logic [37:0] exp_v, act_v;

    vecs[0] = '{"v_mid_l2",   4'b0100, 340, 4'b0100, 4'b0100, 1'b0};
    vecs[1] = '{"v_top_l0",   4'b0001, 330, 4'b0001, 4'b0001, 1'b0};
    vecs[2] = '{"v_bot_l3",   4'b1000, 349, 4'b1000, 4'b1000, 1'b0};
    vecs[3] = '{"v_above",    4'b0010, 329, 4'b0010, 4'b0000, 1'b1};
    vecs[4] = '{"v_below",    4'b0010, 350, 4'b0010, 4'b0000, 1'b1};
    vecs[5] = '{"v_two_of4",  4'b1111, 335, 4'b1010, 4'b1010, 1'b0};
    vecs[6] = '{"v_hit_ghst", 4'b0001, 340, 4'b0011, 4'b0001, 1'b1};
    vecs[7] = '{"v_idle",     4'b0000, 340, 4'b0000, 4'b0000, 1'b0};

    bus.frame_clk = 1'b0;
    bus.n_reg     = '0;
    bus.buttons   = '0;
    bus.active    = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_score", bus.score, 0);
    chk("rst_streak", bus.streak, 0);
    chk("rst_mult", bus.multiplier, 1);
    chk("rst_pulses", {bus.hit_pulse, bus.miss_pulse, bus.ghost_pulse}, 0);

    // Single hit, then re-press of the consumed note ghosts
    bus.active = 1'b1;
    bus.n_reg[2][340] = 1'b1;
    cyc();
    bus.buttons = 4'b0100;
    cyc();
    chk("hit_l2_pulse", bus.hit_pulse, 4'b0100);
    chk("hit_l2_score", bus.score, 10);
    chk("hit_l2_streak", bus.streak, 1);
    chk("hit_l2_mult", bus.multiplier, 1);
    bus.buttons = '0;
    cyc();
    chk("hit_pulse_1cyc", bus.hit_pulse, 0);
    bus.buttons = 4'b0100;
    cyc();
    chk("repress_ghost", {bus.hit_pulse, bus.ghost_pulse}, 5'b00001);
    chk("repress_streak", bus.streak, 0);
    bus.buttons = '0;
    cyc();

    // Table of single-press vectors, masks flushed before each
    for (int i = 0; i < 8; i++) begin
      bus.buttons = '0;
      bus.active = 1'b0;
      bus.n_reg = '0;
      for (int l = 0; l < 4; l++) if (vecs[i].lanes[l]) bus.n_reg[l][vecs[i].row] = 1'b1;
      cyc();
      bus.active = 1'b1;
      cyc();
      bus.buttons = vecs[i].btn;
      cyc();
      chk({vecs[i].name, "_hit"}, bus.hit_pulse, vecs[i].exp_hit);
      chk({vecs[i].name, "_ghost"}, bus.ghost_pulse, vecs[i].exp_ghost);
      bus.buttons = '0;
      cyc();
    end

    // Unhit note at the bottom row misses on tick
    do_reset();
    bus.active = 1'b1;
    bus.n_reg = '0;
    for (int r = 330; r <= 334; r++) bus.n_reg[1][r] = 1'b1;
    for (int i = 0; i < 5; i++) tap(4'b0010);
    chk("miss_pre_streak", bus.streak, 5);
    bus.n_reg[0][349] = 1'b1;
    bus.frame_clk = 1'b1;
    cyc();
    cyc();
    chk("miss_not_early", bus.miss_pulse, 0);
    cyc();
    chk("miss_l0_pulse", bus.miss_pulse, 4'b0001);
    chk("miss_streak", bus.streak, 0);
    chk("miss_score", bus.score, 50);
    bus.frame_clk = 1'b0;
    cyc();

    // Press and tick in the same cycle on the bottom row
    do_reset();
    bus.active = 1'b1;
    bus.n_reg = '0;
    bus.n_reg[1][349] = 1'b1;
    cyc();
    bus.frame_clk = 1'b1;
    cyc();
    cyc();
    bus.buttons = 4'b0010;
    cyc();
    chk("same_cyc_hit", bus.hit_pulse, 4'b0010);
    chk("same_cyc_nomiss", bus.miss_pulse, 4'b0000);
    chk("same_cyc_streak", bus.streak, 1);
    bus.buttons = '0;
    bus.frame_clk = 1'b0;
    cyc();

    // Multiplier step from 1 to 2 across a double hit
    do_reset();
    bus.active = 1'b1;
    bus.n_reg = '0;
    for (int r = 330; r <= 338; r++) bus.n_reg[1][r] = 1'b1;
    for (int i = 0; i < 9; i++) tap(4'b0010);
    chk("mult_pre", {bus.score, bus.streak}, {16'd90, 10'd9});
    bus.n_reg[0][340] = 1'b1;
    bus.n_reg[3][340] = 1'b1;
    bus.buttons = 4'b1001;
    cyc();
    chk("dbl_hit_pulse", bus.hit_pulse, 4'b1001);
    chk("dbl_hit_score", bus.score, 110);
    chk("dbl_hit_streak", bus.streak, 11);
    chk("dbl_hit_mult", bus.multiplier, 2);
    bus.buttons = '0;
    cyc();
    bus.n_reg[2][345] = 1'b1;
    bus.buttons = 4'b0100;
    cyc();
    chk("m2_score", bus.score, 130);
    bus.buttons = '0;
    cyc();

    // Ghost on an empty lane, then no repeats while held
    do_reset();
    bus.active = 1'b1;
    bus.n_reg = '0;
    bus.n_reg[2][340] = 1'b1;
    tap(4'b0100);
    bus.buttons = 4'b1000;
    cyc();
    chk("ghost_pulse", bus.ghost_pulse, 1);
    chk("ghost_streak", bus.streak, 0);
    g = 0;
    repeat (10) begin
      cyc();
      g += int'(bus.ghost_pulse);
    end
    chk("ghost_held", g, 0);
    bus.buttons = '0;
    cyc();

    // Judging disabled: presses ignored, score held
    bus.active = 1'b0;
    bus.n_reg[2][341] = 1'b1;
    cyc();
    bus.buttons = 4'b0100;
    cyc();
    chk("inactive_pulses", {bus.hit_pulse, bus.ghost_pulse}, 0);
    chk("inactive_score", bus.score, 10);
    bus.buttons = '0;
    bus.active = 1'b1;
    cyc();

    // Reset mid-song makes consumed notes judgeable again
    do_reset();
    bus.active = 1'b1;
    bus.n_reg = '0;
    bus.n_reg[2][340] = 1'b1;
    cyc();
    tap(4'b0100);
    #2 rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc();
    bus.buttons = 4'b0100;
    cyc();
    chk("reset_rejudge", bus.hit_pulse, 4'b0100);
    bus.buttons = '0;
    cyc();

    // Score saturation at multiplier 4, then asynchronous reset
    do_reset();
    bus.active = 1'b1;
    for (int l = 0; l < 4; l++)
      for (int r = HIT_LO; r <= HIT_HI; r++) bus.n_reg[l][r] = 1'b1;
    used = 0;
    guard = 0;
    while (guard < 5000 && m_score + 4 * PTS * ref_mult(m_streak) <= 65530) begin
      if (used == 20) begin
        bus.active = 1'b0; cyc(); bus.active = 1'b1; cyc(); used = 0;
      end
      tap(4'b1111);
      used++; guard++;
    end
    while (guard < 5000 && m_score + PTS * ref_mult(m_streak) <= 65530) begin
      if (used == 20) begin
        bus.active = 1'b0; cyc(); bus.active = 1'b1; cyc(); used = 0;
      end
      tap(4'b0001);
      used++; guard++;
    end
    chk("sat_pre_score", bus.score, m_score);
    chk("sat_pre_mult", bus.multiplier, 4);
    if (used == 20) begin
      bus.active = 1'b0; cyc(); bus.active = 1'b1; cyc();
    end
    bus.buttons = 4'b0001;
    cyc();
    chk("sat_score", bus.score, 65535);
    bus.buttons = '0;
    bus.frame_clk = 1'b1;
    cyc();
    cyc();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_score", bus.score, 0);
    chk("async_rst_streak", bus.streak, 0);
    chk("async_rst_mult", bus.multiplier, 1);
    chk("async_rst_pulses", {bus.hit_pulse, bus.miss_pulse, bus.ghost_pulse}, 0);
    bus.frame_clk = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Randomized run against the reference model
    bus.n_reg = '0;
    bus.active = 1'b1;
    for (int c = 0; c < 400; c++) begin
      bus.active = ($urandom_range(15) != 0);
      if ($urandom_range(5) == 0) bus.frame_clk = ~bus.frame_clk;
      bus.buttons = bus.buttons ^ (4'($urandom) & 4'($urandom));
      if ($urandom_range(7) == 0) begin
        for (int l = 0; l < 4; l++)
          for (int r = HIT_LO - 2; r <= HIT_HI + 2; r++)
            bus.n_reg[l][r] = ($urandom_range(2) == 0);
      end
      cyc();
      exp_v = {16'(m_score), 10'(m_streak), 3'(ref_mult(m_streak)), m_hit, m_miss, m_ghost};
      act_v = {bus.score, bus.streak, bus.multiplier, bus.hit_pulse, bus.miss_pulse, bus.ghost_pulse};
      chk("rand_cycle", act_v, exp_v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
